// File: rtl/axi4_mem_slave_if.sv
// axi4_mem_slave_if: AXI4 bus bundle (AW/W/B/AR/R channels) with master and slave modports
interface axi4_mem_slave_if #(
  parameter int C_ID_LEN = 8,
  parameter int C_DATA_SIZE = 4,
  parameter int C_DATA_LEN = 8*(2**C_DATA_SIZE),
  parameter int C_STRB_LEN = C_DATA_LEN/8
);
  logic [C_ID_LEN-1:0]   axi_awid;
  logic [31:0]           axi_awaddr;
  logic [7:0]            axi_awlen;
  logic [2:0]            axi_awsize;
  logic [1:0]            axi_awburst;
  logic                  axi_awvalid;
  logic                  axi_awready;
  logic [C_DATA_LEN-1:0] axi_wdata;
  logic [C_STRB_LEN-1:0] axi_wstrb;
  logic                  axi_wlast;
  logic                  axi_wvalid;
  logic                  axi_wready;
  logic [C_ID_LEN-1:0]   axi_bid;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;
  logic [C_ID_LEN-1:0]   axi_arid;
  logic [31:0]           axi_araddr;
  logic [7:0]            axi_arlen;
  logic [2:0]            axi_arsize;
  logic [1:0]            axi_arburst;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [C_ID_LEN-1:0]   axi_rid;
  logic [C_DATA_LEN-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;
  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
    input  axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
    output axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 INCR memory responder; ports axi_clk, axi_reset (async high), s = AXI4 slave modport
module axi4_mem_slave #(
  parameter int C_ID_LEN = 8,
  parameter int C_DATA_SIZE = 4,
  parameter int C_DATA_LEN = 8*(2**C_DATA_SIZE),
  parameter int C_STRB_LEN = C_DATA_LEN/8,
  parameter int C_MEM_AW = 10
) (
  input logic axi_clk,
  input logic axi_reset,
  axi4_mem_slave_if.slave s
);
  localparam int LO = C_DATA_SIZE;
  localparam int HI = C_DATA_SIZE + C_MEM_AW - 1;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_t;
  typedef enum logic {R_IDLE, R_DATA} r_st_t;
  logic [C_DATA_LEN-1:0] mem_q [2**C_MEM_AW];
  w_st_t w_st_q;
  logic awready_q, wready_q, bvalid_q, w_err_q;
  logic [C_ID_LEN-1:0] bid_q;
  logic [1:0] bresp_q;
  logic [C_MEM_AW-1:0] w_idx_q;
  logic [7:0] w_len_q;
  logic [8:0] w_cnt_q;
  r_st_t r_st_q;
  logic arready_q, r_done_q, f_v_q, f_l_q, hv_q, hl_q, sv_q, sl_q;
  logic [C_ID_LEN-1:0] rid_q;
  logic [1:0] rresp_q;
  logic [C_MEM_AW-1:0] r_idx_q;
  logic [7:0] r_len_q, r_cnt_q;
  logic [C_DATA_LEN-1:0] rd_q, hd_q, sd_q;
  logic aw_hs, w_hs, w_over, w_bad, w_en, ar_hs, pop, room, issue, issue_last;
  logic [1:0] occ;
  logic [C_MEM_AW-1:0] rd_idx;
  logic unused;
  assign unused = ^{s.axi_awaddr[31:HI+1], s.axi_awaddr[LO-1:0], s.axi_araddr[31:HI+1], s.axi_araddr[LO-1:0]};
  assign aw_hs = s.axi_awvalid & awready_q;
  assign w_hs = s.axi_wvalid & wready_q;
  assign w_over = w_cnt_q > {1'b0, w_len_q};
  assign w_bad = w_err_q | w_over | (s.axi_wlast & (w_cnt_q != {1'b0, w_len_q}));
  assign w_en = w_hs & ~w_over;
  assign ar_hs = s.axi_arvalid & arready_q;
  assign pop = hv_q & s.axi_rready;
  assign occ = 2'(hv_q) + 2'(sv_q) + 2'(f_v_q);
  assign room = pop ? occ != 2'd3 : occ < 2'd2;
  assign issue = ar_hs | ((r_st_q == R_DATA) & ~r_done_q & room);
  assign rd_idx = r_st_q == R_IDLE ? s.axi_araddr[HI:LO] : r_idx_q;
  assign issue_last = r_st_q == R_IDLE ? s.axi_arlen == 8'd0 : r_cnt_q == r_len_q;
  assign s.axi_awready = awready_q;
  assign s.axi_wready = wready_q;
  assign s.axi_bvalid = bvalid_q;
  assign s.axi_bid = bid_q;
  assign s.axi_bresp = bresp_q;
  assign s.axi_arready = arready_q;
  assign s.axi_rvalid = hv_q;
  assign s.axi_rdata = hd_q;
  assign s.axi_rlast = hl_q;
  assign s.axi_rid = rid_q;
  assign s.axi_rresp = rresp_q;
  always_ff @(posedge axi_clk) begin
    rd_q <= mem_q[rd_idx];
    for (int b = 0; b < C_STRB_LEN; b++)
      if (w_en && s.axi_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s.axi_wdata[8*b +: 8];
  end
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      w_st_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bid_q <= '0;
      bresp_q <= 2'b00;
      w_idx_q <= '0;
      w_len_q <= 8'd0;
      w_cnt_q <= 9'd0;
      w_err_q <= 1'b0;
    end else begin
      case (w_st_q)
        W_IDLE: begin
          awready_q <= ~aw_hs;
          if (aw_hs) begin
            bid_q <= s.axi_awid;
            w_idx_q <= s.axi_awaddr[HI:LO];
            w_len_q <= s.axi_awlen;
            w_cnt_q <= 9'd0;
            w_err_q <= (s.axi_awsize != 3'(C_DATA_SIZE)) | (s.axi_awburst != 2'b01);
            wready_q <= 1'b1;
            w_st_q <= W_DATA;
          end
        end
        W_DATA: if (w_hs) begin
          w_idx_q <= w_idx_q + 1'b1;
          w_cnt_q <= w_cnt_q + 9'd1;
          w_err_q <= w_bad;
          if (s.axi_wlast) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q <= {w_bad, 1'b0};
            w_st_q <= W_RESP;
          end
        end
        W_RESP: if (s.axi_bready) begin
          bvalid_q <= 1'b0;
          awready_q <= 1'b1;
          w_st_q <= W_IDLE;
        end
        default: w_st_q <= W_IDLE;
      endcase
    end
  end
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_st_q <= R_IDLE;
      arready_q <= 1'b0;
      rid_q <= '0;
      rresp_q <= 2'b00;
      r_idx_q <= '0;
      r_len_q <= 8'd0;
      r_cnt_q <= 8'd0;
      r_done_q <= 1'b0;
      f_v_q <= 1'b0;
      f_l_q <= 1'b0;
      hv_q <= 1'b0;
      hd_q <= '0;
      hl_q <= 1'b0;
      sv_q <= 1'b0;
      sd_q <= '0;
      sl_q <= 1'b0;
    end else begin
      f_v_q <= issue;
      if (issue) begin
        f_l_q <= issue_last;
        r_done_q <= issue_last;
        r_idx_q <= rd_idx + 1'b1;
        r_cnt_q <= r_st_q == R_IDLE ? 8'd1 : r_cnt_q + 8'd1;
      end
      if (~hv_q | pop) begin
        hv_q <= sv_q | f_v_q;
        if (sv_q | f_v_q) begin
          hd_q <= sv_q ? sd_q : rd_q;
          hl_q <= sv_q ? sl_q : f_l_q;
        end
        sv_q <= sv_q & f_v_q;
        if (sv_q) begin
          sd_q <= rd_q;
          sl_q <= f_l_q;
        end
      end else if (f_v_q & ~sv_q) begin
        sv_q <= 1'b1;
        sd_q <= rd_q;
        sl_q <= f_l_q;
      end
      case (r_st_q)
        R_IDLE: begin
          arready_q <= ~ar_hs;
          if (ar_hs) begin
            rid_q <= s.axi_arid;
            rresp_q <= {(s.axi_arsize != 3'(C_DATA_SIZE)) | (s.axi_arburst != 2'b01), 1'b0};
            r_len_q <= s.axi_arlen;
            r_st_q <= R_DATA;
          end
        end
        R_DATA: if (pop & hl_q) begin
          arready_q <= 1'b1;
          r_st_q <= R_IDLE;
        end
        default: r_st_q <= R_IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi4_mem_slave.md
Name: axi4_mem_slave

Overview:
- AXI4 responder (slave) with an internal word-addressed memory array.
- Serves INCR bursts from the frame-buffer AXI master, with independent write and read channels.
- Used as a simulation and on-chip stand-in for the DDR controller, and as a small scratch buffer.
- One outstanding write burst and one outstanding read burst at a time; the two run concurrently.

Parameters:
- C_ID_LEN, 8, width of the ID fields.
- C_DATA_SIZE, 4, log2 of bytes per beat; the AxSIZE value that is supported.
- C_DATA_LEN, 8*(2**C_DATA_SIZE), data width in bits.
- C_STRB_LEN, C_DATA_LEN/8, strobe width.
- C_MEM_AW, 10, log2 of memory depth in words (default 1024 words).

Ports:
- axi_clk  in  1  single clock.
- axi_reset  in  1  asynchronous reset, active-high.
- axi_awid  in  C_ID_LEN  write ID.
- axi_awaddr  in  32  byte address.
- axi_awlen  in  8  beats-1.
- axi_awsize  in  3  beat size.
- axi_awburst  in  2  burst type.
- axi_awvalid  in  1  / axi_awready  out  1  write-address handshake.
- axi_wdata  in  C_DATA_LEN  / axi_wstrb  in  C_STRB_LEN  / axi_wlast  in  1  write data.
- axi_wvalid  in  1  / axi_wready  out  1  write-data handshake.
- axi_bid  out  C_ID_LEN  / axi_bresp  out  2  write response.
- axi_bvalid  out  1  / axi_bready  in  1  write-response handshake.
- axi_arid  in  C_ID_LEN  / axi_araddr  in  32  / axi_arlen  in  8  / axi_arsize  in  3  / axi_arburst  in  2  read address.
- axi_arvalid  in  1  / axi_arready  out  1  read-address handshake.
- axi_rid  out  C_ID_LEN  / axi_rdata  out  C_DATA_LEN  / axi_rresp  out  2  / axi_rlast  out  1  read data.
- axi_rvalid  out  1  / axi_rready  in  1  read-data handshake.

Behaviour:
- Reset: all outputs are 0 while axi_reset is high; reset takes effect asynchronously. Memory contents are not reset.
- One clock after reset release: axi_awready=1 and axi_arready=1.
- Addressing: word index = AxADDR[C_DATA_SIZE+C_MEM_AW-1 : C_DATA_SIZE]; the low C_DATA_SIZE bits are ignored.
- The index increments by 1 per beat and wraps modulo 2**C_MEM_AW.
- Error marking: AxSIZE != C_DATA_SIZE or AxBURST != 2'b01 is still executed as INCR at full width, but the response is SLVERR (2'b10). Otherwise the response is OKAY (2'b00).
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1, wready=0. On awvalid&awready, latch id, index and len; set beat count to 0; go to W_DATA; awready drops next cycle.
  - W_DATA: wready=1. Each wvalid&wready beat writes the bytes whose wstrb bit is 1 and increments index and count.
  - Beats after beat len are accepted but not written, and flag SLVERR.
  - wlast on a beat other than beat len flags SLVERR.
  - The burst ends on the handshake beat with wlast=1 -> W_RESP.
  - W_RESP: bvalid=1 with bid = latched id and bresp = accumulated error. Hold until bready, then -> W_IDLE (awready=1 on the next cycle).
  - A wvalid that arrives before the AW handshake is stalled (wready=0).
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready, latch id, index and len; go to R_DATA.
  - First rvalid is asserted exactly 2 cycles after the AR handshake cycle (1-cycle synchronous memory read plus output register).
  - rdata/rid/rresp/rlast must stay stable while rvalid&!rready.
  - With rready held at 1, beats issue back-to-back with no bubbles. This requires prefetch plus a 2-entry skid/output buffer.
  - rlast=1 only on beat len. The handshake of that beat -> R_IDLE; arready=1 on the following cycle.
- Same-cycle read and write to the same word: the read returns the old data (read-before-write).
- Reset mid-burst: both FSMs return to IDLE, and partially written words keep whatever was already written.

Test Plan:
- Write 4 beats (awlen=3, addr 0x100, data k+1, wstrb all 1) then read back 4 beats -> bresp=0; rdata 1,2,3,4; rlast only on beat 3; first rvalid 2 cycles after AR handshake.
- 128-beat write and read at addr 0x800 with rready and bready held 1 -> 128 consecutive rvalid cycles, no gaps; rid equals arid=0x5A.
- Random rready/wvalid back-pressure on a 16-beat burst -> rdata stable while stalled; readback matches written data exactly.
- Partial strobe: wstrb=16'h00FF over 0xFFFF..F, with the word preset to 0 -> readback has low 8 bytes 0xFF and high 8 bytes 0x00.
- Early wlast on beat 1 of awlen=3 -> bresp=2'b10; only beats 0-1 written; the next AW is accepted.
- Wrap: addr at last word, awlen=1 -> second beat lands in word 0. Assert axi_reset mid read burst -> rvalid=0 immediately; arready=1 one cycle after release.
